// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues one read per load, waits for a variable-latency ack,
// extracts and extends the loaded data, and returns a tagged result with an error code.
module mem_load_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [3:0]        i_ld_op,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_old,
  input  logic [4:0]        i_ld_tag,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic [4:0]        o_res_tag,
  output logic [1:0]        o_res_err
);

  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWU = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_LWL = 4'd7;
  localparam logic [3:0] OP_LWR = 4'd8;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  logic [1:0]        r_state;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_old;
  logic [4:0]        r_tag;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_req;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [1:0]        r_res_err;
  logic [7:0]        r_cnt;

  logic              w_illegal;
  logic              w_misal;

  always_comb begin
    w_illegal = (i_ld_op > OP_LWR);
    if (DATA_W == 32 && (i_ld_op == OP_LWU || i_ld_op == OP_LD)) w_illegal = 1'b1;
    if (DATA_W == 64 && (i_ld_op == OP_LWL || i_ld_op == OP_LWR)) w_illegal = 1'b1;
    w_misal = 1'b0;
    case (i_ld_op)
      OP_LH, OP_LHU: w_misal = i_ld_addr[0];
      OP_LW, OP_LWU: w_misal = |i_ld_addr[1:0];
      OP_LD:         w_misal = |i_ld_addr[2:0];
      default:       w_misal = 1'b0;
    endcase
  end

  // Shifting brings lane `off` to the MSB end (big-endian) or LSB end (little-endian),
  // so every access size is then a fixed slice.
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_shl;
  logic [DATA_W-1:0] w_shr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;

  always_comb begin
    w_off = r_addr[OFF_W-1:0];
    w_shl = i_mem_rdata << {w_off, 3'b000};
    w_shr = i_mem_rdata >> {w_off, 3'b000};
    if (BIG_ENDIAN != 0) begin
      w_byte = w_shl[DATA_W-1 -: 8];
      w_half = w_shl[DATA_W-1 -: 16];
      w_word = w_shl[DATA_W-1 -: 32];
    end else begin
      w_byte = w_shr[7:0];
      w_half = w_shr[15:0];
      w_word = w_shr[31:0];
    end
  end

  // LWL/LWR merge, defined on the low 32 bits with big-endian byte numbering.
  logic [1:0]  w_o;
  logic [2:0]  w_o1;
  logic [31:0] w_rd32;
  logic [31:0] w_old32;
  logic [31:0] w_lmask;
  logic [31:0] w_rmask;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;

  always_comb begin
    w_o     = (BIG_ENDIAN != 0) ? r_addr[1:0] : 2'd3 - r_addr[1:0];
    w_o1    = {1'b0, w_o} + 3'd1;
    w_rd32  = i_mem_rdata[31:0];
    w_old32 = r_old[31:0];
    w_lmask = 32'((64'd1 << {w_o, 3'b000}) - 64'd1);
    w_rmask = 32'((64'd1 << {w_o1, 3'b000}) - 64'd1);
    w_lwl   = (w_rd32 << {w_o, 3'b000}) | (w_old32 & w_lmask);
    w_lwr   = (w_rd32 >> {2'd3 - w_o, 3'b000}) | (w_old32 & ~w_rmask);
  end

  logic [DATA_W-1:0] w_ext;

  always_comb begin
    case (r_op)
      OP_LB:   w_ext = DATA_W'($signed(w_byte));
      OP_LBU:  w_ext = DATA_W'(w_byte);
      OP_LH:   w_ext = DATA_W'($signed(w_half));
      OP_LHU:  w_ext = DATA_W'(w_half);
      OP_LW:   w_ext = DATA_W'($signed(w_word));
      OP_LWU:  w_ext = DATA_W'(w_word);
      OP_LD:   w_ext = i_mem_rdata;
      OP_LWL:  w_ext = DATA_W'(w_lwl);
      OP_LWR:  w_ext = DATA_W'(w_lwr);
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_old       <= '0;
      r_tag       <= '0;
      r_mem_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= ERR_OK;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_ld_valid) begin
          r_op       <= i_ld_op;
          r_addr     <= i_ld_addr;
          r_old      <= i_ld_old;
          r_tag      <= i_ld_tag;
          r_mem_addr <= {i_ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_cnt      <= '0;
          if (w_illegal || w_misal) begin
            r_state     <= S_RESP;
            r_res_valid <= 1'b1;
            r_res_data  <= '0;
            r_res_err   <= w_illegal ? ERR_ILL : ERR_MIS;
          end else begin
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          // An ack arriving on the limit cycle still completes normally.
          if (i_mem_ack) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_data  <= w_ext;
            r_res_err   <= ERR_OK;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_data  <= '0;
            r_res_err   <= ERR_TOUT;
            r_cnt       <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: if (i_res_ready) begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ld_ready  = (r_state == S_IDLE);
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_tag   = r_tag;
  assign o_res_err   = r_res_err;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit (32-bit, big-endian, TIMEOUT=4): directed cases plus random
// loads compared against a byte-level reference model.
module tb_mem_load_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic          ld_ready;
  logic [3:0]    ld_op;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_old;
  logic [4:0]    ld_tag;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [4:0]    res_tag;
  logic [1:0]    res_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_load_unit #(.DATA_W(DW), .ADDR_W(AW), .BIG_ENDIAN(1), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_op(ld_op), .i_ld_addr(ld_addr),
    .i_ld_old(ld_old), .i_ld_tag(ld_tag),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_res_tag(res_tag), .o_res_err(res_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {err, data}; memory word viewed as bytes in address order (byte 0 = MSB).
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] addr,
                                        input logic [31:0] old, input logic [31:0] rdata);
    logic [7:0]  b [4];
    logic [63:0] r;
    logic [63:0] mk;
    int off;
    for (int i = 0; i < 4; i++) b[i] = rdata[31-8*i -: 8];
    off = int'(addr[1:0]);
    case (op)
      4'd0: return {2'b00, {{24{b[off][7]}}, b[off]}};
      4'd1: return {2'b00, {24'h0, b[off]}};
      4'd2, 4'd3: begin
        if (off % 2 != 0) return {2'b01, 32'h0};
        if (op == 4'd2) return {2'b00, {{16{b[off][7]}}, b[off], b[off+1]}};
        return {2'b00, {16'h0, b[off], b[off+1]}};
      end
      4'd4: begin
        if (off != 0) return {2'b01, 32'h0};
        return {2'b00, b[0], b[1], b[2], b[3]};
      end
      4'd7: begin
        mk = (64'd1 << (8*off)) - 64'd1;
        r  = ({32'h0, rdata} << (8*off)) | ({32'h0, old} & mk);
        return {2'b00, r[31:0]};
      end
      4'd8: begin
        mk = (64'd1 << (8*(off+1))) - 64'd1;
        r  = ({32'h0, rdata} >> (8*(3-off))) | ({32'h0, old} & ~mk);
        return {2'b00, r[31:0]};
      end
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  // ack_cyc: cycle (1 = first REQ cycle) in which mem_ack is given; 0 = never.
  task automatic run_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] old, input logic [31:0] rdata,
                          input logic [4:0] tag, input int ack_cyc, input int hold);
    logic [33:0] m;
    logic [1:0]  eerr;
    logic [31:0] edata;
    int          res_cyc;
    m     = model(op, addr, old, rdata);
    eerr  = m[33:32];
    edata = m[31:0];
    chk({nm, ".ld_ready0"}, ld_ready, 1);
    ld_valid = 1; ld_op = op; ld_addr = addr; ld_old = old; ld_tag = tag; res_ready = 0;
    step();
    if (eerr != 2'b00) res_cyc = 1;
    else if (ack_cyc >= 1 && ack_cyc <= TO) res_cyc = ack_cyc + 1;
    else begin
      res_cyc = TO + 1; eerr = 2'b11; edata = 32'h0;
    end
    for (int c = 1; c < res_cyc; c++) begin
      ld_valid = 1'($urandom_range(0, 1)); ld_op = 4'($urandom); ld_addr = $urandom;
      ld_old = $urandom; ld_tag = 5'($urandom);
      chk({nm, ".mem_req"}, mem_req, 1);
      chk({nm, ".res_valid_early"}, res_valid, 0);
      chk({nm, ".mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
      chk({nm, ".ld_ready_busy"}, ld_ready, 0);
      mem_ack   = (c == ack_cyc);
      mem_rdata = (c == ack_cyc) ? rdata : $urandom;
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      ld_valid = 1'($urandom_range(0, 1)); ld_op = 4'($urandom); ld_addr = $urandom;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      chk({nm, ".mem_req_off"}, mem_req, 0);
      chk({nm, ".res_valid"}, res_valid, 1);
      chk({nm, ".res_data"}, res_data, edata);
      chk({nm, ".res_err"}, res_err, eerr);
      chk({nm, ".res_tag"}, res_tag, tag);
      chk({nm, ".ld_ready_resp"}, ld_ready, 0);
      if (h < hold) step();
    end
    ld_valid = 0; res_ready = 1;
    step();
    res_ready = 0; mem_ack = 0;
    chk({nm, ".res_valid_done"}, res_valid, 0);
    chk({nm, ".ld_ready_done"}, ld_ready, 1);
  endtask

  initial begin
    rst = 1; ld_valid = 0; ld_op = 0; ld_addr = 0; ld_old = 0; ld_tag = 0;
    mem_ack = 0; mem_rdata = 0; res_ready = 0;
    step(); step();
    chk("rst.ld_ready", ld_ready, 1);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_data", res_data, 0);
    chk("rst.res_err", res_err, 0);
    chk("rst.res_tag", res_tag, 0);
    chk("rst.mem_addr", mem_addr, 0);
    rst = 0;

    run_load("t1_lb",   4'd0, 32'h101, 32'h0, 32'h1180_2233, 5'd3, 1, 0);
    run_load("t2_lhu",  4'd3, 32'h102, 32'h0, 32'hAAAA_9ABC, 5'd4, 4, 0);
    run_load("t3_lwmis",4'd4, 32'h6,   32'h0, 32'h1234_5678, 5'd5, 1, 0);
    run_load("t3_ld",   4'd6, 32'h8,   32'h0, 32'h1234_5678, 5'd6, 1, 0);
    run_load("t4_lwl",  4'd7, 32'h1, 32'hAABB_CCDD, 32'h1122_3344, 5'd7, 2, 0);
    run_load("t4_lwr",  4'd8, 32'h1, 32'hAABB_CCDD, 32'h1122_3344, 5'd8, 2, 0);
    run_load("t5_tout", 4'd4, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd9, 0, 0);
    run_load("t5_edge", 4'd4, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd10, 4, 0);
    run_load("t6_hold", 4'd2, 32'h22, 32'h0, 32'h8765_4321, 5'd11, 3, 5);

    // Reset while REQ is outstanding; a late ack must not produce a result.
    ld_valid = 1; ld_op = 4'd4; ld_addr = 32'h80; ld_tag = 5'd12;
    step();
    ld_valid = 0;
    chk("rstmid.mem_req_on", mem_req, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rstmid.mem_req", mem_req, 0);
    chk("rstmid.ld_ready", ld_ready, 1);
    chk("rstmid.res_data", res_data, 0);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 0;
    step();
    chk("rstmid.late_ack_valid", res_valid, 0);
    chk("rstmid.late_ack_req", mem_req, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 10));
      if (op == 4'd10) op = 4'($urandom_range(9, 15));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_load($sformatf("rnd%0d", i), op, a, $urandom, $urandom, 5'($urandom),
               $urandom_range(0, 6), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
